// File: rtl/sound_cue_arbiter_if.sv
// rtl/sound_cue_arbiter_if.sv - event-request / audio-control bundle for sound_cue_arbiter
interface sound_cue_arbiter_if;
    logic [3:0] req;
    logic       mute;
    logic [2:0] audio_sel;
    logic       audio_en;
    logic [3:0] grant;
    logic [3:0] pending;
    logic       busy;

    modport master (
        output req, mute,
        input  audio_sel, audio_en, grant, pending, busy
    );

    modport slave (
        input  req, mute,
        output audio_sel, audio_en, grant, pending, busy
    );
endinterface

// File: rtl/sound_cue_arbiter.sv
// rtl/sound_cue_arbiter.sv - fixed-priority arbiter sharing one tone generator among four game events
module sound_cue_arbiter #(
    parameter int         CUE_LEN = 25_000_000,
    parameter int         GAP_LEN = 5_000_000,
    parameter logic [2:0] SEL0    = 3'd1,
    parameter logic [2:0] SEL1    = 3'd2,
    parameter logic [2:0] SEL2    = 3'd3,
    parameter logic [2:0] SEL3    = 3'd4,
    parameter int         CNT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    sound_cue_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] CUE_LOAD = CNT_W'(CUE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

    state_t           state, nextState;
    logic [CNT_W-1:0] count, nextCount;
    logic [3:0]       pending, nextPending, grant, nextGrant, clearMask;
    logic [2:0]       audioSel, nextSel;
    logic [1:0]       curIdx, nextIdx, topIdx;
    logic             topValid, doGrant, goIdle;

    function automatic logic [2:0] selFor(input logic [1:0] idx);
        case (idx)
            2'd0:    return SEL0;
            2'd1:    return SEL1;
            2'd2:    return SEL2;
            default: return SEL3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            pending  <= '0;
            grant    <= '0;
            audioSel <= '0;
            curIdx   <= '0;
        end else begin
            state    <= nextState;
            count    <= nextCount;
            pending  <= nextPending;
            grant    <= nextGrant;
            audioSel <= nextSel;
            curIdx   <= nextIdx;
        end
    end

    // Ascending scan leaves the highest set index in topIdx.
    always_comb begin
        topValid = |pending;
        topIdx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i]) topIdx = i[1:0];
        end
    end

    always_comb begin
        nextState = state;
        nextCount = count;
        nextGrant = grant;
        nextSel   = audioSel;
        nextIdx   = curIdx;
        clearMask = '0;
        doGrant   = 1'b0;
        goIdle    = 1'b0;
        case (state)
            IDLE: doGrant = topValid;
            PLAY: begin
                if (topValid && (topIdx > curIdx)) begin
                    doGrant = 1'b1;
                end else if (count == '0) begin
                    if (GAP_LEN == 0) begin
                        doGrant = topValid;
                        goIdle  = !topValid;
                    end else begin
                        nextState = GAP;
                        nextCount = GAP_LOAD;
                        nextGrant = '0;
                        nextSel   = '0;
                    end
                end else begin
                    nextCount = count - 1'b1;
                end
            end
            GAP: begin
                if (count == '0) begin
                    doGrant = topValid;
                    goIdle  = !topValid;
                end else begin
                    nextCount = count - 1'b1;
                end
            end
            default: goIdle = 1'b1;
        endcase
        if (doGrant) begin
            nextState = PLAY;
            nextCount = CUE_LOAD;
            nextGrant = 4'b0001 << topIdx;
            nextSel   = selFor(topIdx);
            nextIdx   = topIdx;
            clearMask = 4'b0001 << topIdx;
        end
        if (goIdle) begin
            nextState = IDLE;
            nextCount = '0;
            nextGrant = '0;
            nextSel   = '0;
        end
        // A request arriving in the same cycle its bit is cleared stays latched.
        nextPending = (pending & ~clearMask) | bus.req;
    end

    always_comb begin
        bus.audio_en  = (state == PLAY) && !bus.mute;
        bus.busy      = (state != IDLE);
        bus.audio_sel = audioSel;
        bus.grant     = grant;
        bus.pending   = pending;
    end
endmodule

// File: tb/tb_sound_cue_arbiter.sv
// tb/tb_sound_cue_arbiter.sv - directed self-checking bench for sound_cue_arbiter
module tb_sound_cue_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   asserts = 0;
    int   failures = 0;

    sound_cue_arbiter_if bus ();

    sound_cue_arbiter #(.CUE_LEN(8), .GAP_LEN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectPlay(input string tag, input logic [3:0] g, input logic [2:0] sel, input logic en);
        chk({tag, " grant"}, 32'(bus.grant), 32'(g));
        chk({tag, " sel"},   32'(bus.audio_sel), 32'(sel));
        chk({tag, " en"},    32'(bus.audio_en), 32'(en));
        chk({tag, " busy"},  32'(bus.busy), 32'd1);
    endtask

    task automatic expectGap(input string tag);
        chk({tag, " grant"}, 32'(bus.grant), 32'd0);
        chk({tag, " sel"},   32'(bus.audio_sel), 32'd0);
        chk({tag, " en"},    32'(bus.audio_en), 32'd0);
        chk({tag, " busy"},  32'(bus.busy), 32'd1);
    endtask

    task automatic expectIdle(input string tag);
        chk({tag, " grant"}, 32'(bus.grant), 32'd0);
        chk({tag, " sel"},   32'(bus.audio_sel), 32'd0);
        chk({tag, " en"},    32'(bus.audio_en), 32'd0);
        chk({tag, " busy"},  32'(bus.busy), 32'd0);
    endtask

    task automatic pulse(input logic [3:0] r);
        bus.req = r;
        tick();
        bus.req = 4'b0000;
    endtask

    initial begin
        bus.req  = 4'b0000;
        bus.mute = 1'b0;
        #2;
        expectIdle("reset");
        chk("reset pending", 32'(bus.pending), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        expectIdle("post-reset");

        // single low-priority cue: 8 play cycles, 3 gap cycles, idle
        pulse(4'b0001);
        chk("t1 pending", 32'(bus.pending), 32'b0001);
        expectIdle("t1 latch");
        for (int i = 0; i < 8; i++) begin tick(); expectPlay("t1 play", 4'b0001, 3'd1, 1'b1); end
        chk("t1 pending clr", 32'(bus.pending), 32'd0);
        for (int i = 0; i < 3; i++) begin tick(); expectGap("t1 gap"); end
        tick();
        expectIdle("t1 idle");

        // two simultaneous requests: higher first, lower straight from GAP
        pulse(4'b0110);
        chk("t2 pending", 32'(bus.pending), 32'b0110);
        tick();
        expectPlay("t2 first", 4'b0100, 3'd3, 1'b1);
        chk("t2 pending left", 32'(bus.pending), 32'b0010);
        for (int i = 1; i < 8; i++) begin tick(); expectPlay("t2 play hi", 4'b0100, 3'd3, 1'b1); end
        for (int i = 0; i < 3; i++) begin tick(); expectGap("t2 gap"); end
        for (int i = 0; i < 8; i++) begin tick(); expectPlay("t2 play lo", 4'b0010, 3'd2, 1'b1); end
        for (int i = 0; i < 3; i++) begin tick(); expectGap("t2 gap2"); end
        tick();
        expectIdle("t2 idle");

        // preemption of req[0] by req[3] during its third cue cycle
        pulse(4'b0001);
        tick();
        expectPlay("t3 c1", 4'b0001, 3'd1, 1'b1);
        tick();
        tick();
        expectPlay("t3 c3", 4'b0001, 3'd1, 1'b1);
        pulse(4'b1000);
        chk("t3 pending", 32'(bus.pending), 32'b1000);
        expectPlay("t3 c4", 4'b0001, 3'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin tick(); expectPlay("t3 preempt", 4'b1000, 3'd4, 1'b1); end
        for (int i = 0; i < 3; i++) begin tick(); expectGap("t3 gap"); end
        tick();
        expectIdle("t3 no replay");
        chk("t3 pending", 32'(bus.pending), 32'd0);

        // request during GAP waits for the gap to finish
        pulse(4'b0001);
        for (int i = 0; i < 8; i++) tick();
        expectPlay("t4 last", 4'b0001, 3'd1, 1'b1);
        pulse(4'b0010);
        expectGap("t4 gap1");
        chk("t4 pending", 32'(bus.pending), 32'b0010);
        tick();
        expectGap("t4 gap2");
        tick();
        expectGap("t4 gap3");
        tick();
        expectPlay("t4 after gap", 4'b0010, 3'd2, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        tick();
        expectIdle("t4 idle");

        // mute: same sequencing, enable held low
        bus.mute = 1'b1;
        pulse(4'b0001);
        chk("t5 pending", 32'(bus.pending), 32'b0001);
        for (int i = 0; i < 8; i++) begin tick(); expectPlay("t5 muted", 4'b0001, 3'd1, 1'b0); end
        for (int i = 0; i < 3; i++) begin tick(); expectGap("t5 gap"); end
        tick();
        expectIdle("t5 idle");
        bus.mute = 1'b0;

        // async reset mid-cue drops everything pending
        pulse(4'b1000);
        tick();
        expectPlay("t6 play", 4'b1000, 3'd4, 1'b1);
        pulse(4'b1010);
        chk("t6 pending", 32'(bus.pending), 32'b1010);
        expectPlay("t6 still", 4'b1000, 3'd4, 1'b1);
        rst = 1'b1;
        #1;
        expectIdle("t6 async rst");
        chk("t6 pending rst", 32'(bus.pending), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); expectIdle("t6 after rst"); end
        chk("t6 pending after", 32'(bus.pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
